// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA geometry, capture FSM states and frame-size helper.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  typedef enum logic [1:0] {IDLE, WAIT_VSYNC, CAPTURE, DONE} estado_captura_t;
  function automatic int frame_words(input int decim, input int h, input int v);
    return (h / decim) * (v / decim);
  endfunction
endpackage

// File: rtl/detector_flancos.sv
// detector_flancos: registers a 1-bit input and flags its rising/falling edges.
module detector_flancos #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic q_q, prev_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      q_q    <= d;
      prev_q <= q_q;
    end
  end
  assign q    = q_q;
  assign rise = q_q & ~prev_q;
  assign fall = ~q_q & prev_q;
endmodule

// File: rtl/vga_captura.sv
// vga_captura: captures one decimated VGA frame into a linear frame buffer.
module vga_captura
  import vga_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DECIM  = 2,
  parameter int H_ACT  = H_ACTIVE,
  parameter int V_ACT  = V_ACTIVE
) (
  input  logic              clock_25,
  input  logic              reset,
  input  logic              start,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              n_blank,
  input  logic [7:0]        red,
  input  logic [7:0]        green,
  input  logic [7:0]        blue,
  output logic [ADDR_W-1:0] address,
  output logic [23:0]       data_out,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic              frame_error
);
  localparam int XW = $clog2(H_ACT + 1);
  localparam int YW = $clog2(V_ACT + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(frame_words(DECIM, H_ACT, V_ACT) - 1);
  estado_captura_t state_q, state_d;
  logic start_q, hs_q, unused_hs;
  logic vs_fall, nb_q, nb_fall, unused_vs_q, unused_vs_rise, unused_nb_rise;
  logic [23:0] rgb_q, data_q, data_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d, address_q, address_d;
  logic full_q, full_d, we_q, we_d, err_q, err_d, store;
  detector_flancos #(.RST_VAL(1'b1)) u_vs (
    .clk(clock_25), .rst(reset), .d(vsync),
    .q(unused_vs_q), .rise(unused_vs_rise), .fall(vs_fall)
  );
  detector_flancos #(.RST_VAL(1'b0)) u_nb (
    .clk(clock_25), .rst(reset), .d(n_blank),
    .q(nb_q), .rise(unused_nb_rise), .fall(nb_fall)
  );
  assign unused_hs = hs_q;
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    wptr_d    = wptr_q;
    full_d    = full_q;
    address_d = address_q;
    data_d    = data_q;
    we_d      = 1'b0;
    err_d     = err_q;
    store     = 1'b0;
    case (state_q)
      IDLE: if (start_q) begin
        state_d = WAIT_VSYNC;
        err_d   = 1'b0;
      end
      WAIT_VSYNC: if (vs_fall) begin
        state_d   = CAPTURE;
        x_d       = '0;
        y_d       = '0;
        wptr_d    = '0;
        full_d    = 1'b0;
        address_d = '0;
      end
      CAPTURE: begin
        x_d   = nb_q ? ((&x_q) ? x_q : x_q + 1'b1) : '0;
        store = nb_q && (DECIM == 1 || !x_q[0]) && (DECIM == 1 || !y_q[0]);
        if (store && full_q) err_d = 1'b1;
        if (store && !full_q) begin
          we_d      = 1'b1;
          address_d = wptr_q;
          data_d    = rgb_q;
          full_d    = wptr_q == LAST;
          wptr_d    = (wptr_q == LAST) ? wptr_q : wptr_q + 1'b1;
        end
        if (nb_fall) begin
          y_d = y_q + 1'b1;
          if (x_q != XW'(H_ACT)) err_d = 1'b1;
          if (y_q == YW'(V_ACT - 1)) state_d = DONE;
        end
        // an early vsync means the frame was truncated: restart on the next one
        if (vs_fall) begin
          state_d   = WAIT_VSYNC;
          err_d     = 1'b1;
          we_d      = 1'b0;
          wptr_d    = '0;
          full_d    = 1'b0;
          address_d = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock_25) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      hs_q      <= 1'b1;
      rgb_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      wptr_q    <= '0;
      full_q    <= 1'b0;
      address_q <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      hs_q      <= hsync;
      rgb_q     <= {red, green, blue};
      x_q       <= x_d;
      y_q       <= y_d;
      wptr_q    <= wptr_d;
      full_q    <= full_d;
      address_q <= address_d;
      data_q    <= data_d;
      we_q      <= we_d;
      err_q     <= err_d;
    end
  end
  assign address     = address_q;
  assign data_out    = data_q;
  assign we          = we_q;
  assign busy        = state_q == WAIT_VSYNC || state_q == CAPTURE;
  assign done        = state_q == DONE;
  assign frame_error = err_q;
endmodule

// File: tb/tb_vga_captura.sv
// tb_vga_captura: directed frames against vga_captura with a short vertical size.
module tb_vga_captura;
  import vga_pkg::*;
  localparam int H = 640;
  localparam int V = 16;
  localparam int W = H / 2;
  localparam int WORDS = W * (V / 2);
  logic clk = 1'b0, reset = 1'b1, start = 1'b1, hsync = 1'b1, vsync = 1'b1, n_blank = 1'b0;
  logic [7:0] red = '0, green = '0, blue = '0;
  logic [17:0] address;
  logic [23:0] data_out;
  logic we, busy, done, frame_error;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int we_cnt = 0, done_cnt = 0, exp_idx = 0, last_addr = -1;
  int hit_cyc = -1, drive_cyc = -100, col, row;
  logic [23:0] hit_data = '0;
  logic mon_en = 1'b0, pulse_mid = 1'b0;
  vga_captura #(.ADDR_W(18), .DECIM(2), .H_ACT(H), .V_ACT(V)) dut (
    .clock_25(clk), .reset(reset), .start(start), .hsync(hsync), .vsync(vsync),
    .n_blank(n_blank), .red(red), .green(green), .blue(blue), .address(address),
    .data_out(data_out), .we(we), .busy(busy), .done(done), .frame_error(frame_error)
  );
  always #20 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [23:0] pix(input int x, input int y);
    logic [9:0] xv;
    logic [7:0] yv;
    xv = 10'(x);
    yv = 8'(y);
    return (x == 2 && y == 2) ? 24'hAABBCC : {xv[7:0], 6'd0, xv[9:8], yv};
  endfunction
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (we) begin
      we_cnt++;
      last_addr = int'(address);
      if (mon_en) begin
        col = exp_idx % W;
        row = exp_idx / W;
        chk("wr_addr", 32'(address), 32'(exp_idx));
        chk("wr_data", 32'(data_out), 32'(pix(col * 2, row * 2)));
        if (address == 18'd321) begin
          hit_cyc  = cyc;
          hit_data = data_out;
        end
        exp_idx++;
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic vs_pulse();
    vsync = 1'b0;
    tick(2);
    vsync = 1'b1;
    tick(6);
  endtask
  task automatic line(input int y, input int len);
    for (int x = 0; x < len; x++) begin
      n_blank = 1'b1;
      {red, green, blue} = pix(x, y);
      start = pulse_mid && y == 5 && x == 100;
      if (x == 2 && y == 2) drive_cyc = cyc;
      if (pulse_mid && y == 5 && x == 110) chk("mid_start_state", 32'(dut.state_q), 32'(CAPTURE));
      tick(1);
    end
    start = 1'b0;
    n_blank = 1'b0;
    {red, green, blue} = '0;
    for (int b = 0; b < 20; b++) begin
      hsync = !(b >= 4 && b < 12);
      tick(1);
    end
  endtask
  task automatic frame(input int nlines, input int short_y, input int short_len);
    vs_pulse();
    for (int y = 0; y < nlines; y++) line(y, (y == short_y) ? short_len : H);
    tick(4);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
  endtask
  initial begin
    tick(3);
    reset = 1'b0;
    start = 1'b0;
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(frame_error), 32'd0);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    tick(3);
    chk("rst_start_ignored", 32'(dut.state_q), 32'(IDLE));
    mon_en = 1'b1;
    exp_idx = 0;
    we_cnt = 0;
    done_cnt = 0;
    pulse_start();
    chk("f1_busy", 32'(busy), 32'd1);
    pulse_mid = 1'b1;
    frame(V, -1, 0);
    pulse_mid = 1'b0;
    chk("f1_we_cnt", 32'(we_cnt), 32'(WORDS));
    chk("f1_last_addr", 32'(last_addr), 32'(WORDS - 1));
    chk("f1_done_cnt", 32'(done_cnt), 32'd1);
    chk("f1_err", 32'(frame_error), 32'd0);
    chk("f1_latency", 32'(hit_cyc - drive_cyc), 32'd2);
    chk("f1_hit_data", 32'(hit_data), 32'hAABBCC);
    chk("f1_idle", 32'(dut.state_q), 32'(IDLE));
    chk("f1_busy_off", 32'(busy), 32'd0);
    mon_en = 1'b0;
    we_cnt = 0;
    done_cnt = 0;
    pulse_start();
    frame(V, 10, 600);
    chk("f2_err", 32'(frame_error), 32'd1);
    chk("f2_done_cnt", 32'(done_cnt), 32'd1);
    chk("f2_we_cnt", 32'(we_cnt), 32'(WORDS - 20));
    chk("f2_last_addr", 32'(last_addr), 32'(WORDS - 21));
    mon_en = 1'b1;
    exp_idx = 0;
    we_cnt = 0;
    done_cnt = 0;
    pulse_start();
    chk("f3_err_cleared", 32'(frame_error), 32'd0);
    frame(8, -1, 0);
    chk("f3_part_we_cnt", 32'(we_cnt), 32'(W * 4));
    vs_pulse();
    chk("f3_abort_err", 32'(frame_error), 32'd1);
    chk("f3_abort_addr", 32'(address), 32'd0);
    chk("f3_abort_state", 32'(dut.state_q), 32'(WAIT_VSYNC));
    chk("f3_abort_no_done", 32'(done_cnt), 32'd0);
    exp_idx = 0;
    we_cnt = 0;
    frame(V, -1, 0);
    chk("f3_we_cnt", 32'(we_cnt), 32'(WORDS));
    chk("f3_done_cnt", 32'(done_cnt), 32'd1);
    chk("f3_err_sticky", 32'(frame_error), 32'd1);
    mon_en = 1'b0;
    done_cnt = 0;
    pulse_start();
    vs_pulse();
    line(0, H);
    line(1, H);
    n_blank = 1'b1;
    {red, green, blue} = 24'h123456;
    tick(10);
    chk("mid_state", 32'(dut.state_q), 32'(CAPTURE));
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    n_blank = 1'b0;
    chk("mr_state", 32'(dut.state_q), 32'(IDLE));
    chk("mr_we", 32'(we), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_err", 32'(frame_error), 32'd0);
    chk("mr_addr", 32'(address), 32'd0);
    chk("mr_data", 32'(data_out), 32'd0);
    tick(4);
    chk("mr_no_done", 32'(done_cnt), 32'd0);
    chk("mr_still_idle", 32'(dut.state_q), 32'(IDLE));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_captura.md
VGA_CAPTURA -- requirements
Module: vga_captura

Interface
REQ-001 Parameter ADDR_W, default 18: width of the frame-buffer write address.
REQ-002 Parameter DECIM, default 2: horizontal and vertical decimation factor (1 or 2).
REQ-003 clock_25  in  1: pixel clock; all logic is on its rising edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 start  in  1: one-cycle pulse that arms capture of the next full frame.
REQ-006 hsync, vsync  in  1 each: incoming syncs, both active-low.
REQ-007 n_blank  in  1: high during active video.
REQ-008 red, green, blue  in  8 each: incoming pixel colour.
REQ-009 address  out  ADDR_W: frame-buffer write address.
REQ-010 data_out  out  24: write data, packed {red, green, blue}.
REQ-011 we  out  1: write enable, one cycle per stored pixel.
REQ-012 busy  out  1: high in the WAIT_VSYNC and CAPTURE states.
REQ-013 done  out  1: one-cycle pulse when a frame is complete.
REQ-014 frame_error  out  1: sticky flag; cleared by reset or start.

Function
REQ-015 All inputs SHALL pass through one register stage before use; this register also supplies the previous-value copies used for edge detection.
REQ-016 The FSM SHALL have four states: IDLE, WAIT_VSYNC, CAPTURE, DONE.
REQ-017 IDLE goes to WAIT_VSYNC on start; start is ignored in every other state.
REQ-018 WAIT_VSYNC goes to CAPTURE on the registered vsync falling edge; line and pixel counters clear on that edge.
REQ-019 In CAPTURE, the pixel counter x SHALL increment each cycle registered n_blank is high and clear when it is low.
REQ-020 In CAPTURE, the line counter y SHALL increment on each registered n_blank falling edge.
REQ-021 A pixel SHALL be stored when n_blank is high, x mod DECIM == 0 and y mod DECIM == 0.
REQ-022 For a stored pixel, we is asserted and data_out is valid one cycle after that pixel is registered, giving 2 cycles of input-to-we latency.
REQ-023 address SHALL start at 0 each frame and increment by 1 after each write; writes are sequential with no multiplier.
REQ-024 CAPTURE goes to DONE when y reaches 480 (640x480 timing).
REQ-025 DONE SHALL pulse done for 1 cycle, then return to IDLE.
REQ-026 Any active line whose length is not 640 SHALL set frame_error; capture continues.
REQ-027 A vsync falling edge in CAPTURE with y < 480 SHALL set frame_error and return to WAIT_VSYNC with address reset to 0.
REQ-028 address SHALL saturate at (640/DECIM)*(480/DECIM)-1; writes beyond that are suppressed and set frame_error.
REQ-029 we SHALL be 0 outside CAPTURE.

Reset
REQ-030 When reset is high, the state SHALL become IDLE, all counters 0, address 0, data_out 0, and we, busy, done and frame_error 0.
REQ-031 Reset SHALL take priority over start and over any in-progress capture; a partial frame is abandoned with no done pulse.
REQ-032 The input register SHALL reset to the idle line state: hsync=1, vsync=1, n_blank=0.

Structure
REQ-033 Package vga_pkg SHALL hold H_ACTIVE=640, V_ACTIVE=480, the state typedef estado_captura_t, and the function computing the frame size per DECIM.
REQ-034 The sub-module detector_flancos (1-bit registered rising/falling edge detector) SHALL be instantiated for vsync and n_blank.
REQ-035 Synthesis target: 120-400 lines of RTL total.

Verification
REQ-036 Reset held 3 cycles, mid-CAPTURE -> all outputs 0, state IDLE, no done pulse.
REQ-037 DECIM=2, start, one clean 640x480 frame driven with x-gradient pixels -> exactly 76800 we pulses, addresses 0..76799, done pulses once, frame_error=0.
REQ-038 Pixel (2,2) = 0xAABBCC -> address 321 written with 0xAABBCC, 2 cycles after that pixel is presented.
REQ-039 Line 10 shortened to 600 pixels -> frame_error=1, capture completes with done.
REQ-040 vsync falls after 100 lines -> frame_error=1, address returns to 0, next full frame is captured to done.
REQ-041 start pulsed during CAPTURE, and start coincident with reset -> both ignored; state unchanged and IDLE respectively.
